// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: SLIP-style framing constants, arbiter FSM states and source indices.
package uart_frame_pkg;
  localparam logic [7:0] FRAME_DELIM = 8'h7E;
  localparam logic [7:0] FRAME_ESC   = 8'h7D;
  localparam logic [7:0] ESC_XOR     = 8'h20;
  localparam int SRC_RESPONSE = 0;
  localparam int SRC_PHY      = 1;
  localparam int SRC_OUTPUT   = 2;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_TYPE,
    ST_LOAD,
    ST_DATA,
    ST_ESC,
    ST_EOF
  } arb_state_t;
  function automatic logic is_special(input logic [7:0] b);
    return (b == FRAME_DELIM) || (b == FRAME_ESC);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request strictly after the last grant.
module rr_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int GW      = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [GW-1:0]      i_last_grant,
  output logic [GW-1:0]      o_grant,
  output logic               o_any
);
  function automatic logic [GW-1:0] cand(input logic [GW-1:0] last, input int k);
    int v;
    v = int'(last) + k;
    if (v >= NUM_SRC) v -= NUM_SRC;
    return GW'(v);
  endfunction
  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    o_grant = i_last_grant;
    o_any   = |i_req;
    for (int k = NUM_SRC; k >= 1; k--)
      if (i_req[cand(i_last_grant, k)]) o_grant = cand(i_last_grant, k);
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-atomic round-robin mux of AXI-Stream sources onto the UART byte path,
// wrapping each packet as 7E, type, byte-stuffed payload, 7E.
module uart_tx_arbiter
  import uart_frame_pkg::*;
#(
  parameter int         DATA_WIDTH = 64,
  parameter int         NUM_SRC    = 3,
  parameter logic [7:0] TYPE_BASE  = 8'h01
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_SRC*DATA_WIDTH/8-1:0] s_tkeep,
  input  logic [NUM_SRC-1:0]              s_tlast,
  input  logic [NUM_SRC-1:0]              s_tvalid,
  output logic [NUM_SRC-1:0]              s_tready,
  output logic [7:0]                      m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [$clog2(NUM_SRC)-1:0]      grant,
  output logic                            busy
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int GW = $clog2(NUM_SRC);

  arb_state_t r_state, w_state_n;
  logic [7:0] r_tdata, w_tdata_n;
  logic r_tvalid, w_tvalid_n;
  logic [GW-1:0] r_grant, w_grant_n, r_last_grant, w_last_grant_n, w_pick;
  logic w_any;
  logic [DATA_WIDTH-1:0] r_data, w_data_n, w_sdata;
  logic [NB-1:0] r_keep, w_keep_n, w_skeep, w_rem;
  logic r_blast, w_blast_n, w_slast, w_svalid;
  logic [7:0] w_cbyte, w_nbyte, w_sbyte;
  logic w_xfer, w_adv;

  function automatic logic [IW-1:0] lowest(input logic [NB-1:0] k);
    logic [IW-1:0] r;
    r = '0;
    for (int i = NB - 1; i >= 0; i--) if (k[i]) r = IW'(i);
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [DATA_WIDTH-1:0] d, input logic [IW-1:0] i);
    return d[8*i +: 8];
  endfunction

  rr_arbiter #(.NUM_SRC(NUM_SRC), .GW(GW)) u_rr (
    .i_req        (s_tvalid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick),
    .o_any        (w_any)
  );

  assign w_sdata  = s_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
  assign w_skeep  = s_tkeep[r_grant*NB +: NB];
  assign w_slast  = s_tlast[r_grant];
  assign w_svalid = s_tvalid[r_grant];
  // r_keep still includes the byte on the wire; w_rem is what is left once it is gone.
  assign w_rem    = r_keep & (r_keep - 1'b1);
  assign w_cbyte  = get_byte(r_data, lowest(r_keep));
  assign w_nbyte  = get_byte(r_data, lowest(w_rem));
  assign w_sbyte  = get_byte(w_sdata, lowest(w_skeep));
  assign w_xfer   = r_tvalid & m_tready;
  assign w_adv    = w_xfer && ((r_state == ST_ESC) || (r_state == ST_DATA && !is_special(w_cbyte)));

  assign s_tready = (r_state == ST_LOAD) ? (NUM_SRC'(1) << r_grant) : '0;
  assign m_tdata  = r_tdata;
  assign m_tvalid = r_tvalid;
  assign grant    = r_grant;
  assign busy     = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_grant      <= GW'(SRC_RESPONSE);
      r_last_grant <= GW'(NUM_SRC - 1);
      r_data       <= '0;
      r_keep       <= '0;
      r_blast      <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_tdata      <= w_tdata_n;
      r_tvalid     <= w_tvalid_n;
      r_grant      <= w_grant_n;
      r_last_grant <= w_last_grant_n;
      r_data       <= w_data_n;
      r_keep       <= w_keep_n;
      r_blast      <= w_blast_n;
    end
  end

  // The state names what is currently presented on the registered byte output.
  always_comb begin
    w_state_n      = r_state;
    w_tdata_n      = r_tdata;
    w_tvalid_n     = r_tvalid;
    w_grant_n      = r_grant;
    w_last_grant_n = r_last_grant;
    w_data_n       = r_data;
    w_keep_n       = r_keep;
    w_blast_n      = r_blast;
    case (r_state)
      ST_IDLE: if (w_any) begin
        w_grant_n  = w_pick;
        w_state_n  = ST_SOF;
        w_tvalid_n = 1'b1;
        w_tdata_n  = FRAME_DELIM;
      end
      ST_SOF: if (w_xfer) begin
        w_state_n = ST_TYPE;
        w_tdata_n = TYPE_BASE + 8'(r_grant);
      end
      ST_TYPE: if (w_xfer) begin
        w_state_n  = ST_LOAD;
        w_tvalid_n = 1'b0;
      end
      ST_LOAD: if (w_svalid) begin
        w_data_n  = w_sdata;
        w_keep_n  = w_skeep;
        w_blast_n = w_slast;
        if (|w_skeep) begin
          w_state_n  = ST_DATA;
          w_tvalid_n = 1'b1;
          w_tdata_n  = is_special(w_sbyte) ? FRAME_ESC : w_sbyte;
        end else if (w_slast) begin
          w_state_n  = ST_EOF;
          w_tvalid_n = 1'b1;
          w_tdata_n  = FRAME_DELIM;
        end
      end
      ST_DATA: if (w_xfer && is_special(w_cbyte)) begin
        w_state_n = ST_ESC;
        w_tdata_n = w_cbyte ^ ESC_XOR;
      end
      ST_EOF: if (w_xfer) begin
        w_state_n      = ST_IDLE;
        w_tvalid_n     = 1'b0;
        w_last_grant_n = r_grant;
      end
      default: ;
    endcase
    if (w_adv) begin
      w_keep_n = w_rem;
      if (|w_rem) begin
        w_state_n = ST_DATA;
        w_tdata_n = is_special(w_nbyte) ? FRAME_ESC : w_nbyte;
      end else if (r_blast) begin
        w_state_n = ST_EOF;
        w_tdata_n = FRAME_DELIM;
      end else begin
        w_state_n  = ST_LOAD;
        w_tvalid_n = 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed frames with a byte scoreboard fed from the packets as they are queued.
module tb_uart_tx_arbiter;
  import uart_frame_pkg::*;
  localparam int DW = 64;
  localparam int NS = 3;
  localparam int KW = DW / 8;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic clk, rst_n, m_tready, m_tvalid, busy;
  logic [NS*DW-1:0] s_tdata;
  logic [NS*KW-1:0] s_tkeep;
  logic [NS-1:0] s_tlast, s_tvalid, s_tready, hs;
  logic [7:0] m_tdata, prev_d;
  logic [1:0] grant;
  logic prev_stall;
  int checks, errors;
  beat_t srcq[NS][$];
  logic [7:0] exp_q[$];

  uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .TYPE_BASE(8'h01)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tlast  (s_tlast),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .grant    (grant),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic pkt_start(input int src);
    exp_q.push_back(8'h7E);
    exp_q.push_back(8'h01 + 8'(src));
  endtask

  task automatic beat(input int src, input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    beat_t b;
    logic [7:0] by;
    b.d = d;
    b.k = k;
    b.l = l;
    srcq[src].push_back(b);
    for (int i = 0; i < KW; i++) if (k[i]) begin
      by = d[8*i +: 8];
      if (by == 8'h7E || by == 8'h7D) begin
        exp_q.push_back(8'h7D);
        exp_q.push_back(by ^ 8'h20);
      end else exp_q.push_back(by);
    end
    if (l) exp_q.push_back(8'h7E);
  endtask

  task automatic drain(input string tag, input int max, input bit tog);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < max) begin
      @(posedge clk);
      #2;
      if (tog) m_tready = ~m_tready;
      n++;
    end
    m_tready = 1'b1;
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  // Source drivers: pop a beat after the handshake seen at the previous negedge.
  initial begin
    s_tdata = '0;
    s_tkeep = '0;
    s_tlast = '0;
    s_tvalid = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        if (srcq[i].size() > 0) begin
          s_tvalid[i] = 1'b1;
          s_tdata[i*DW +: DW] = srcq[i][0].d;
          s_tkeep[i*KW +: KW] = srcq[i][0].k;
          s_tlast[i] = srcq[i][0].l;
        end else s_tvalid[i] = 1'b0;
      end
    end
  end

  // Output monitor: scoreboard, stall stability and ready exclusivity.
  initial begin
    hs = '0;
    prev_stall = 1'b0;
    prev_d = '0;
    forever begin
      @(negedge clk);
      hs = s_tvalid & s_tready;
      if (!rst_n) prev_stall = 1'b0;
      else begin
        if (prev_stall) begin
          chk("stall_valid", m_tvalid, 1);
          chk("stall_data", m_tdata, prev_d);
        end
        if (|s_tready) begin
          chk("tready_onehot", s_tready, 3'b001 << grant);
          chk("tready_only_load", m_tvalid, 0);
        end
        if (m_tvalid && m_tready) begin
          checks++;
          assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL sb_unexpected observed=%0h expected=none", m_tdata);
          end
          if (exp_q.size() > 0) chk("sb_byte", m_tdata, exp_q.pop_front());
        end
        prev_stall = m_tvalid && !m_tready;
        prev_d = m_tdata;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    pkt_start(SRC_RESPONSE);
    beat(SRC_RESPONSE, 64'h0807060504030201, 8'hFF, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_tvalid[0] && n < 20);
    chk("lat_c0_valid", m_tvalid, 0);
    @(negedge clk);
    chk("lat_c1_valid", m_tvalid, 1);
    chk("lat_c1_sof", m_tdata, 8'h7E);
    chk("lat_c1_busy", busy, 1);
    chk("lat_c1_grant", grant, 0);
    drain("single", 100, 1'b0);

    pkt_start(SRC_PHY);
    beat(SRC_PHY, 64'h0000_0000_0041_7D7E, 8'h07, 1'b1);
    drain("escape", 100, 1'b0);

    pkt_start(SRC_OUTPUT);
    beat(SRC_OUTPUT, 64'hDEAD_BEEF_4433_2211, 8'h0F, 1'b0);
    beat(SRC_OUTPUT, 64'hFFFF_FFFF_FFFF_6655, 8'h03, 1'b1);
    drain("backpressure", 200, 1'b1);

    pkt_start(0); beat(0, 64'hA0, 8'h01, 1'b1);
    pkt_start(1); beat(1, 64'hB0, 8'h01, 1'b1);
    pkt_start(2); beat(2, 64'hC0, 8'h01, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy && grant == 2'd2) && n < 200);
    chk("rr_src2_granted", {busy, grant}, 3'b110);
    pkt_start(0); beat(0, 64'hD0, 8'h01, 1'b1);
    drain("roundrobin", 300, 1'b0);

    pkt_start(SRC_PHY);
    beat(SRC_PHY, 64'h1817161514131211, 8'hFF, 1'b0);
    beat(SRC_PHY, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b1);
    drain("edge_empty_last", 200, 1'b0);
    pkt_start(SRC_RESPONSE);
    beat(SRC_RESPONSE, 64'h8877665544332211, 8'hA5, 1'b1);
    drain("edge_holes", 200, 1'b0);

    pkt_start(SRC_RESPONSE);
    beat(SRC_RESPONSE, 64'h1122334455667_7AA, 8'hFF, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_tvalid && m_tdata == 8'hAA) && n < 50);
    chk("mid_reach_data", m_tdata, 8'hAA);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", m_tvalid, 0);
    chk("mid_rst_m_tdata", m_tdata, 0);
    chk("mid_rst_s_tready", s_tready, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    exp_q.delete();
    for (int i = 0; i < NS; i++) srcq[i].delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    pkt_start(SRC_RESPONSE);
    beat(SRC_RESPONSE, 64'h0807060504030201, 8'hFF, 1'b1);
    drain("after_reset", 100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-atomic round-robin arbiter that shares the single UART transmit byte path between several AXI-Stream packet sources (TCP response stream, PHY TX frames, processed TCP output data). It sits between those `DATA_WIDTH`-wide streams and the byte-wide transmit input of the UART core. Each granted packet is serialized into bytes and wrapped in a SLIP-style frame: start delimiter, type byte, byte-stuffed payload, end delimiter. The host can therefore demultiplex the streams.

## Interface
- `DATA_WIDTH`, 64: width of each source `tdata`; must be a multiple of 8.
- `NUM_SRC`, 3: number of sources, 2..8.
- `TYPE_BASE`, 8'h01: type byte sent for source i is `TYPE_BASE + i`.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `s_tdata`  in  `NUM_SRC*DATA_WIDTH`  source data; source i occupies slice i.
- `s_tkeep`  in  `NUM_SRC*DATA_WIDTH/8`  byte enables per source.
- `s_tlast`  in  `NUM_SRC`  end of packet.
- `s_tvalid`  in  `NUM_SRC`  beat valid.
- `s_tready`  out  `NUM_SRC`  beat accept.
- `m_tdata`  out  8  byte to UART TX.
- `m_tvalid`  out  1  byte valid.
- `m_tready`  in  1  UART TX accepts byte.
- `grant`  out  `$clog2(NUM_SRC)`  index of source currently owning the link.
- `busy`  out  1  a frame is in progress (state ≠ IDLE).

## Operation
- States: IDLE → SOF → TYPE → LOAD → DATA ⇄ ESC → (LOAD | EOF) → IDLE.
- IDLE:
  - If any `s_tvalid` is high, the round-robin pick is the first valid index strictly after `last_grant`, wrapping.
  - Register the pick in `grant`, then go to SOF.
- SOF: emit 8'h7E.
- TYPE: emit `TYPE_BASE + grant`. The type byte is not escaped; the legal parameter range guarantees it is never 7E/7D.
- LOAD:
  - `s_tready[grant]` = 1; all other `s_tready` bits are 0.
  - On `s_tvalid[grant]`, capture tdata/tkeep/tlast into the beat register and go to DATA.
  - If the beat has tkeep = 0: go to EOF when tlast is set, otherwise stay in LOAD.
- DATA:
  - Emit the lowest-indexed remaining kept byte. Byte k is `tdata[8k+7:8k]`. Holes in tkeep are skipped.
  - If the byte is 7E or 7D, emit 8'h7D and go to ESC.
  - After the last kept byte is accepted: go to EOF if the beat had tlast, otherwise go to LOAD.
- ESC: emit `byte ^ 8'h20`, then continue as DATA.
- EOF:
  - Emit 8'h7E.
  - On acceptance, set `last_grant` = `grant` and go to IDLE.
- A byte is transferred when `m_tvalid && m_tready`. State advances only on a transfer. The exceptions are IDLE and LOAD, which advance on source handshakes.
- Grant is held for the whole packet. Requests from other sources arriving mid-frame wait.
- If the granted source deasserts tvalid mid-packet, the block waits in LOAD indefinitely. There is no timeout.

## Timing
- Reset values:
  - `m_tvalid` = 0, `m_tdata` = 0, `s_tready` = 0, `grant` = 0, `busy` = 0.
  - State = IDLE; `last_grant` = `NUM_SRC-1`, so source 0 wins first.
- `m_tdata` and `m_tvalid` are registered. `m_tdata` is held stable while `m_tvalid && !m_tready`.
- `s_tready` is combinational from state and `grant` only; it never depends on `s_tvalid`.
- Latency: with `s_tvalid` high in IDLE at cycle 0, SOF appears on `m_tvalid` at cycle 1.
- Throughput:
  - 1 byte/cycle with `m_tready` held high.
  - One LOAD cycle per beat.
  - One extra cycle per escaped byte.
- `busy` is high from the cycle after the grant through EOF acceptance.
- Reset asserted mid-frame: the frame is abandoned with no EOF, and all outputs return to reset values immediately.

## Structure
- Package `uart_frame_pkg` contains:
  - constants `FRAME_DELIM` = 8'h7E, `FRAME_ESC` = 8'h7D, `ESC_XOR` = 8'h20;
  - the `arb_state_t` enum;
  - source index localparams `SRC_RESPONSE` = 0, `SRC_PHY` = 1, `SRC_OUTPUT` = 2.
- One sub-module, `rr_arbiter`: combinational round-robin pick. Inputs: request vector and `last_grant`. Outputs: grant index and any-request flag.
- Byte serialization and escaping stay in the top module.

## Test plan
- Single packet, source 0, one beat:
  - Stimulus: tdata 64'h0807060504030201, tkeep FF, tlast 1.
  - Expected: 7E 01 01 02 03 04 05 06 07 08 7E.
- Escaping, source 1:
  - Stimulus: bytes 7E 7D 41, tkeep 8'h07.
  - Expected: 7E 02 7D 5E 7D 5D 41 7E.
- Round robin:
  - Stimulus: sources 0, 1 and 2 all hold one-beat packets from cycle 0.
  - Expected: frames are emitted in type order 01, 02, 03. A new packet on source 0 queued during the source-2 frame is served after it.
- Backpressure:
  - Stimulus: `m_tready` toggles 1/0 during a two-beat packet with tkeep 8'h0F then 8'h03.
  - Expected: `m_tdata` is stable while stalled; 6 payload bytes in order; `s_tready` high only in LOAD.
- Edge beats:
  - Stimulus: a tkeep = 0 beat with tlast = 1 after a full beat.
  - Expected: EOF immediately follows the 8 payload bytes.
- Reset mid-frame:
  - Stimulus: `rst_n` low during DATA.
  - Expected: all outputs are 0 the same cycle. After release, a new source-0 packet is framed correctly starting with 7E 01.
